// File: rtl/simple_processor_pkg.sv
// +------------------------------------------------------------------+
// | simple_processor_pkg : shared decode types, opcodes and decoder  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package simple_processor_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [3:0] {
      SLL     = 4'h0,
      SLLI    = 4'h1,
      SLR     = 4'h2,
      SLRI    = 4'h3,
      SRA     = 4'h4,
      SRAI    = 4'h5,
      ROL     = 4'h6,
      ROR     = 4'h7,
      INVALID = 4'hF
   } func_t;

   localparam logic [5:0] OP_SLL  = 6'h00;
   localparam logic [5:0] OP_SLLI = 6'h01;
   localparam logic [5:0] OP_SLR  = 6'h02;
   localparam logic [5:0] OP_SLRI = 6'h03;
   localparam logic [5:0] OP_SRA  = 6'h04;
   localparam logic [5:0] OP_SRAI = 6'h05;
   localparam logic [5:0] OP_ROL  = 6'h06;
   localparam logic [5:0] OP_ROR  = 6'h07;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

   typedef struct packed {
      func_t                   func;
      logic [REG_ADDR_W-1:0]   rd;
      logic [REG_ADDR_W-1:0]   rs1;
      logic [REG_ADDR_W-1:0]   rs2;
      logic [DATA_WIDTH-1:0]   imm;
      logic                    illegal;
   } decoded_instr_t;

   localparam decoded_instr_t DEC_RESET = '{func: INVALID, rd: '0, rs1: '0,
                                            rs2: '0, imm: '0, illegal: 1'b0};

   function automatic decoded_instr_t decode_instr(input logic [31:0] instr);
      decoded_instr_t d;
      d.rd      = instr[25:21];
      d.rs1     = instr[20:16];
      d.rs2     = instr[15:11];
      d.imm     = {{(DATA_WIDTH-6){instr[5]}}, instr[5:0]};
      d.illegal = 1'b0;
      case (instr[31:26])
         OP_SLL:  d.func = SLL;
         OP_SLLI: d.func = SLLI;
         OP_SLR:  d.func = SLR;
         OP_SLRI: d.func = SLRI;
         OP_SRA:  d.func = SRA;
         OP_SRAI: d.func = SRAI;
         OP_ROL:  d.func = ROL;
         OP_ROR:  d.func = ROR;
         default: begin
            d.func    = INVALID;
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/shift_instr_skid.sv
// +------------------------------------------------------------------+
// | shift_instr_skid : main register plus one skid entry, registered |
// | upstream ready. Revision: 1.0                                    |
// +------------------------------------------------------------------+
`default_nettype none

module shift_instr_skid #(
   parameter type T       = logic,
   parameter T    RST_VAL = '0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic flush_i,
   input  T     in_data_i,
   input  logic in_valid_i,
   output logic in_ready_o,
   output T     out_data_o,
   output logic out_valid_o,
   input  logic out_ready_i
);
   import simple_processor_pkg::*;

   skid_state_t state_d, state_q;
   T            main_d, main_q;
   T            skid_d, skid_q;
   logic        ready_d, ready_q;
   logic        accept, xfer;

   assign in_ready_o  = ready_q;
   assign out_valid_o = (state_q != ST_EMPTY);
   assign out_data_o  = main_q;
   assign accept      = in_valid_i & ready_q;
   assign xfer        = out_valid_o & out_ready_i;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = in_data_i;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && xfer) begin
               main_d = in_data_i;
            end else if (accept) begin
               skid_d  = in_data_i;
               state_d = ST_FULL;
            end else if (xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // ready is low here, so only the drain of main can happen
            if (xfer) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush_i) begin
         state_d = ST_EMPTY;
      end
      ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
         ready_q <= 1'b1;
         main_q  <= RST_VAL;
         skid_q  <= RST_VAL;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/shift_instr_decoder.sv
// +------------------------------------------------------------------+
// | shift_instr_decoder : shift-instruction decode stage feeding     |
// | alu_shift through a skid buffer. Revision: 1.0                   |
// +------------------------------------------------------------------+
`default_nettype none

module shift_instr_decoder #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        flush_i,
   input  logic [31:0]                 instr_i,
   input  logic                        instr_valid_i,
   output logic                        instr_ready_o,
   output simple_processor_pkg::func_t func_o,
   output logic [REG_ADDR_W-1:0]       rd_addr_o,
   output logic [REG_ADDR_W-1:0]       rs1_addr_o,
   output logic [REG_ADDR_W-1:0]       rs2_addr_o,
   output logic [DATA_WIDTH-1:0]       imm_o,
   output logic                        illegal_o,
   output logic                        dec_valid_o,
   input  logic                        dec_ready_i,
   output logic [ERR_CNT_W-1:0]        illegal_cnt_o
);
   import simple_processor_pkg::*;

   decoded_instr_t         dec_in;
   decoded_instr_t         dec_out;
   logic                   accept;
   logic [ERR_CNT_W-1:0]   illegal_cnt_d, illegal_cnt_q;

   assign dec_in = decode_instr(instr_i);
   // a word offered during a flush is dropped, so it is not counted
   assign accept = instr_valid_i & instr_ready_o & ~flush_i;

   shift_instr_skid #(
      .T       (decoded_instr_t),
      .RST_VAL (DEC_RESET)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_data_i   (dec_in),
      .in_valid_i  (instr_valid_i),
      .in_ready_o  (instr_ready_o),
      .out_data_o  (dec_out),
      .out_valid_o (dec_valid_o),
      .out_ready_i (dec_ready_i)
   );

   always_comb begin
      illegal_cnt_d = illegal_cnt_q;
      if (accept && dec_in.illegal && (illegal_cnt_q != '1)) begin
         illegal_cnt_d = illegal_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         illegal_cnt_q <= '0;
      end else begin
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign illegal_cnt_o = illegal_cnt_q;
   assign func_o        = dec_out.func;
   assign rd_addr_o     = REG_ADDR_W'(dec_out.rd);
   assign rs1_addr_o    = REG_ADDR_W'(dec_out.rs1);
   assign rs2_addr_o    = REG_ADDR_W'(dec_out.rs2);
   assign imm_o         = DATA_WIDTH'($signed(dec_out.imm));
   assign illegal_o     = dec_out.illegal;

endmodule

`default_nettype wire

// File: tb/tb_shift_instr_decoder.sv
// +------------------------------------------------------------------+
// | tb_shift_instr_decoder : scoreboard bench for shift_instr_decoder|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_shift_instr_decoder;
   import simple_processor_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i, flush_i, instr_valid_i, instr_ready_o;
   logic [31:0] instr_i;
   func_t       func_o;
   logic [4:0]  rd_addr_o, rs1_addr_o, rs2_addr_o;
   logic [31:0] imm_o;
   logic        illegal_o, dec_valid_o, dec_ready_i;
   logic [7:0]  illegal_cnt_o;

   always #5 clk = ~clk;

   shift_instr_decoder dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .instr_i       (instr_i),
      .instr_valid_i (instr_valid_i),
      .instr_ready_o (instr_ready_o),
      .func_o        (func_o),
      .rd_addr_o     (rd_addr_o),
      .rs1_addr_o    (rs1_addr_o),
      .rs2_addr_o    (rs2_addr_o),
      .imm_o         (imm_o),
      .illegal_o     (illegal_o),
      .dec_valid_o   (dec_valid_o),
      .dec_ready_i   (dec_ready_i),
      .illegal_cnt_o (illegal_cnt_o)
   );

   typedef struct {
      func_t       func;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   exp_t cur_exp;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mkexp(input func_t f, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm, input logic ill);
      exp_t e;
      e.func = f; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.ill = ill;
      return e;
   endfunction

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [5:0] imm6);
      return {op, rd, rs1, rs2, 5'b0, imm6};
   endfunction

   // reference decode table for random traffic
   function automatic exp_t model(input logic [31:0] w);
      func_t f;
      logic  ill = 1'b0;
      case (w[31:26])
         6'd0: f = SLL;   6'd1: f = SLLI;  6'd2: f = SLR;   6'd3: f = SLRI;
         6'd4: f = SRA;   6'd5: f = SRAI;  6'd6: f = ROL;   6'd7: f = ROR;
         default: begin f = INVALID; ill = 1'b1; end
      endcase
      return mkexp(f, w[25:21], w[20:16], w[15:11], {{26{w[5]}}, w[5:0]}, ill);
   endfunction

   // input-side monitor: record accepted words, drop everything on flush/reset
   always @(negedge clk) begin
      if (rst_i || flush_i) sb.delete();
      else if (instr_valid_i && instr_ready_o) sb.push_back(cur_exp);
   end

   // output-side monitor: compare each transferred entry against the queue head
   always @(negedge clk) begin
      exp_t e;
      if (!rst_i && !flush_i && dec_valid_o && dec_ready_i) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got func %0h rd %0h with empty scoreboard", func_o, rd_addr_o);
         end else begin
            e = sb.pop_front();
            chk("func",    func_o,     e.func);
            chk("rd",      rd_addr_o,  e.rd);
            chk("rs1",     rs1_addr_o, e.rs1);
            chk("rs2",     rs2_addr_o, e.rs2);
            chk("imm",     imm_o,      e.imm);
            chk("illegal", illegal_o,  e.ill);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w, input exp_t e);
      logic ok = 1'b0;
      instr_i       = w;
      cur_exp       = e;
      instr_valid_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         ok = instr_ready_o;
         tick();
         if (ok) break;
      end
      instr_valid_i = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: ready stayed 0, required 1");
      end
   endtask

   task automatic drain();
      int i = 0;
      instr_valid_i = 1'b0;
      dec_ready_i   = 1'b1;
      while ((sb.size() != 0 || dec_valid_o) && i < 200) begin
         tick();
         i++;
      end
      chk("drain_left", 64'(sb.size()) + 64'(dec_valid_o), 0);
   endtask

   task automatic check_reset();
      chk("rst_valid", dec_valid_o,   0);
      chk("rst_ready", instr_ready_o, 1);
      chk("rst_cnt",   illegal_cnt_o, 0);
      chk("rst_func",  func_o,        INVALID);
      chk("rst_rd",    rd_addr_o,     0);
      chk("rst_rs1",   rs1_addr_o,    0);
      chk("rst_rs2",   rs2_addr_o,    0);
      chk("rst_imm",   imm_o,         0);
      chk("rst_ill",   illegal_o,     0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, wa, wb, wc;
      rst_i = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0; instr_i = '0;
      dec_ready_i = 1'b1; cur_exp = mkexp(INVALID, 0, 0, 0, 0, 0);
      repeat (3) tick();
      rst_i = 1'b0;
      check_reset();

      // single SLLI word, one-cycle latency
      send(32'h0422_1805, mkexp(SLLI, 5'd1, 5'd2, 5'd3, 32'h5, 1'b0));
      chk("lat_valid", dec_valid_o, 1);
      drain();

      // immediate sign extension
      send(mk(6'h03, 5'd4, 5'd5, 5'd6, 6'h3F), mkexp(SLRI, 5'd4, 5'd5, 5'd6, 32'hFFFF_FFFF, 1'b0));
      send(mk(6'h00, 5'd7, 5'd8, 5'd9, 6'h1F), mkexp(SLL,  5'd7, 5'd8, 5'd9, 32'h0000_001F, 1'b0));
      drain();

      // back-pressure: A, B fill main+skid, C waits
      dec_ready_i = 1'b0;
      wa = mk(6'h02, 5'd1, 5'd1, 5'd1, 6'h01);
      wb = mk(6'h04, 5'd2, 5'd2, 5'd2, 6'h22);
      wc = mk(6'h07, 5'd3, 5'd3, 5'd3, 6'h03);
      send(wa, mkexp(SLR, 5'd1, 5'd1, 5'd1, 32'h1, 1'b0));
      send(wb, mkexp(SRA, 5'd2, 5'd2, 5'd2, 32'hFFFF_FFE2, 1'b0));
      chk("ready_full", instr_ready_o, 0);
      instr_i = wc; cur_exp = mkexp(ROR, 5'd3, 5'd3, 5'd3, 32'h3, 1'b0); instr_valid_i = 1'b1;
      tick(); tick();
      chk("ready_full_hold", instr_ready_o, 0);
      chk("hold_func", func_o, SLR);
      chk("hold_imm",  imm_o,  32'h1);
      dec_ready_i = 1'b1;
      send(wc, mkexp(ROR, 5'd3, 5'd3, 5'd3, 32'h3, 1'b0));
      drain();

      // illegal opcodes and counter saturation
      chk("cnt_zero", illegal_cnt_o, 0);
      for (int i = 0; i < 300; i++) begin
         logic [5:0] im;
         im = 6'(i);
         send(mk(6'h3E, 5'(i), 5'(i + 1), 5'(i + 2), im),
              mkexp(INVALID, 5'(i), 5'(i + 1), 5'(i + 2), {{26{im[5]}}, im}, 1'b1));
         if (i == 99) chk("cnt_100", illegal_cnt_o, 100);
      end
      drain();
      chk("cnt_sat", illegal_cnt_o, 255);

      // flush while FULL with a word offered
      dec_ready_i = 1'b0;
      send(mk(6'h05, 5'd10, 5'd11, 5'd12, 6'h10), mkexp(SRAI, 5'd10, 5'd11, 5'd12, 32'h10, 1'b0));
      send(mk(6'h06, 5'd13, 5'd14, 5'd15, 6'h20), mkexp(ROL, 5'd13, 5'd14, 5'd15, 32'hFFFF_FFE0, 1'b0));
      flush_i = 1'b1; instr_valid_i = 1'b1;
      instr_i = mk(6'h01, 5'd31, 5'd31, 5'd31, 6'h3F); cur_exp = model(instr_i);
      tick();
      flush_i = 1'b0; instr_valid_i = 1'b0;
      chk("flush_valid", dec_valid_o,   0);
      chk("flush_ready", instr_ready_o, 1);
      chk("flush_cnt",   illegal_cnt_o, 255);
      dec_ready_i = 1'b1;
      repeat (5) tick();
      chk("flush_quiet", dec_valid_o, 0);

      // reset while FULL, then while ONE
      dec_ready_i = 1'b0;
      send(mk(6'h01, 5'd1, 5'd2, 5'd3, 6'h04), mkexp(SLLI, 5'd1, 5'd2, 5'd3, 32'h4, 1'b0));
      send(mk(6'h02, 5'd4, 5'd5, 5'd6, 6'h05), mkexp(SLR,  5'd4, 5'd5, 5'd6, 32'h5, 1'b0));
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      check_reset();
      send(mk(6'h03, 5'd7, 5'd8, 5'd9, 6'h06), mkexp(SLRI, 5'd7, 5'd8, 5'd9, 32'h6, 1'b0));
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      check_reset();

      // random traffic with random stalls
      for (int c = 0; c < 1000; c++) begin
         r = $urandom;
         if ($urandom_range(0, 3) == 0) r[31:26] = 6'($urandom_range(8, 63));
         else                           r[31:26] = 6'($urandom_range(0, 7));
         instr_i       = r;
         cur_exp       = model(r);
         instr_valid_i = 1'($urandom_range(0, 1));
         dec_ready_i   = ($urandom_range(0, 9) < 7);
         tick();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/shift_instr_decoder.md
Name: shift_instr_decoder

Overview:
- Decode stage that produces the operand-select and function stream consumed by alu_shift: func_t, register addresses and sign-extended immediate.
- Accepts 32-bit instruction words over a valid/ready handshake and presents registered decode results over a second valid/ready handshake.
- Contains a 1-entry main register plus a 1-entry skid buffer, so upstream sees a registered ready with no combinational path from dec_ready_i.
- Sits between instruction fetch and the register-file read / alu_shift execute stage.

Parameters:
- DATA_WIDTH, 32, datapath width; the immediate is sign-extended to this width.
- REG_ADDR_W, 5, register address width.
- ERR_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all held entries (pipeline redirect).
- instr_i  in  32  instruction word.
- instr_valid_i  in  1  instr_i is valid.
- instr_ready_o  out  1  block can accept a word this cycle; registered.
- func_o  out  func_t  decoded function.
- rd_addr_o  out  REG_ADDR_W  destination register, instr[25:21].
- rs1_addr_o  out  REG_ADDR_W  source 1, instr[20:16].
- rs2_addr_o  out  REG_ADDR_W  source 2, instr[15:11].
- imm_o  out  DATA_WIDTH  instr[5:0] sign-extended.
- illegal_o  out  1  the opcode did not decode; func_o = INVALID.
- dec_valid_o  out  1  decoded entry is valid.
- dec_ready_i  in  1  downstream accepts the entry.
- illegal_cnt_o  out  ERR_CNT_W  count of accepted illegal instructions, saturating.

Behaviour:
- Opcode instr[31:26] decodes as follows:
  - 6'h00 -> SLL
  - 6'h01 -> SLLI
  - 6'h02 -> SLR
  - 6'h03 -> SLRI
  - any other opcode listed in the package table -> its func_t value
  - otherwise -> INVALID with illegal_o=1.
- Immediate: imm_o = {{(DATA_WIDTH-6){instr[5]}}, instr[5:0]}. It is computed for every opcode; consumers ignore it for R-type functions.
- Accept condition: accept = instr_valid_i & instr_ready_o. Output transfer: xfer = dec_valid_o & dec_ready_i.
- Latency: a word accepted in cycle N appears on the outputs with dec_valid_o=1 in cycle N+1 when the main register is empty or transferring.
- States, encoded by occupancy of main and skid:
  - EMPTY: dec_valid_o=0, ready=1.
  - ONE: main valid, ready=1.
  - FULL: main and skid valid, ready=0.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept & !xfer -> FULL; the word goes to skid.
  - ONE + accept & xfer -> ONE; main is reloaded.
  - ONE + xfer & !accept -> EMPTY.
  - FULL + xfer -> ONE; skid moves to main. No accept is possible because ready=0.
- instr_ready_o is registered and equals !(next state == FULL).
- Ordering: strict FIFO order; the skid entry never overtakes main.
- Output stability: while dec_valid_o=1 and dec_ready_i=0, every decode output holds stable.
- flush_i:
  - Next state is EMPTY and instr_ready_o=1 next cycle.
  - A word offered in the flush cycle is dropped.
  - flush_i has priority over accept and xfer.
  - illegal_cnt_o is not cleared by flush.
- illegal_cnt_o increments by 1 per accepted word with illegal_o=1, including words later flushed, and saturates at all-ones.
- Reset (rst_i=1 at an edge):
  - dec_valid_o=0, instr_ready_o=1, illegal_cnt_o=0.
  - func_o=INVALID, all address outputs 0, imm_o=0, illegal_o=0.
  - Reset dominates flush and all handshakes. Entries held at the time of reset are lost.

Decomposition:
- simple_processor_pkg:
  - func_t: existing enum; INVALID is required.
  - opcode constants OP_SLL, OP_SLLI, OP_SLR, OP_SLRI.
  - DATA_WIDTH.
  - decoded_instr_t packed struct {func, rd, rs1, rs2, imm, illegal}.
  - pure function decode_instr(logic [31:0]) returning decoded_instr_t.
- Sub-module: shift_instr_skid, a 2-entry skid buffer parameterised on the payload type. The decode itself is combinational ahead of the skid.

Test Plan:
1. Reset, then send 32'h0422_1805 (op 01 SLLI, rd=1, rs1=2, rs2=3, imm=5) with dec_ready_i=1 -> next cycle dec_valid_o=1, func_o=SLLI, rd/rs1/rs2=1/2/3, imm_o=32'h5, illegal_o=0.
2. Send op 03 SLRI with imm6=6'h3F -> imm_o=32'hFFFF_FFFF, func_o=SLRI. Send op 00 with imm6=6'h1F -> imm_o=32'h1F, func_o=SLL.
3. Hold dec_ready_i=0 and offer 3 back-to-back words A, B, C -> A and B accepted, instr_ready_o=0 from the cycle after B. Then raise dec_ready_i -> outputs A, B, C in order, with no loss or duplication.
4. Send 300 words with opcode 6'h3E (unused) -> illegal_o=1 and func_o=INVALID on each; illegal_cnt_o saturates at 255.
5. While in FULL, assert flush_i for 1 cycle together with instr_valid_i=1 -> next cycle dec_valid_o=0, instr_ready_o=1, and the offered word never appears.
6. Assert rst_i mid-stream while in FULL and while in ONE -> next cycle all outputs hold their reset values. Random traffic with random stalls against a reference queue gives 0 mismatches over 1000 cycles.
